i2c_slave_regfile: RTL

- Register-file backend sitting directly downstream of i2c_slave.
- Consumes the slave's byte-level events (START/STOP strobes, received write bytes, transmit-byte requests).
- Implements the standard "pointer byte, then data bytes" register protocol with auto-increment.
- Exposes register 0 as a control output and maps a read-only status input at the top address.

---
 rtl/i2c_slave_regfile.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: register-file backend sitting behind i2c_slave.
// Implements the "pointer byte, then data bytes" protocol. Register 0 drives
// ctrl_out; the top address is read-only and returns the live status_in.
// Build option: define I2C_REGFILE_AUTOINC_EN to post-increment the pointer
// after every data access; left undefined, the pointer stays where the
// pointer byte put it.
module i2c_slave_regfile #(
    parameter int         N_REGS   = 16,
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] RST_CTRL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_start,
    input  logic       bus_stop,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       rd_req,
    input  logic [7:0] status_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] ctrl_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_DATA, ST_BAD} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);

`ifdef I2C_REGFILE_AUTOINC_EN
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
    // A zero step freezes the pointer after the pointer byte.
    localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        regs_q [N_REGS];
    logic [7:0]        regs_d [N_REGS];
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [7:0]        rd_byte;
    logic              ptr_in_range;

    // Next-state, pointer, register-file update and read response.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        busy_d       = busy_q;
        err_d        = err_q;
        rd_byte      = (ptr_q == LAST_ADDR) ? status_in : regs_q[ptr_q];
        ptr_in_range = ({24'd0, wr_data} < 32'(N_REGS));

        // Every read request is answered next cycle; 8'hFF unless a legal
        // read below replaces it.
        if (rd_req) begin
            rd_valid_d = 1'b1;
            rd_data_d  = 8'hFF;
        end

        if (bus_start) begin
            // START wins over everything else; any byte this cycle is dropped
            // and the pointer is kept for a repeated-START read.
            state_d = ST_PTR;
            busy_d  = 1'b1;
        end else begin
            // A write and a read in the same cycle: write proceeds, read fails.
            if (wr_valid && rd_req) begin
                err_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (wr_valid || rd_req) begin
                        err_d = 1'b1;
                    end
                end
                ST_PTR: begin
                    if (wr_valid) begin
                        if (ptr_in_range) begin
                            ptr_d   = wr_data[ADDR_W-1:0];
                            state_d = ST_DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_BAD;
                        end
                    end else if (rd_req) begin
                        // First read after (repeated) START is a data access.
                        rd_data_d = rd_byte;
                        ptr_d     = ptr_q + PTR_STEP;
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_valid) begin
                        if (ptr_q != LAST_ADDR) begin
                            regs_d[ptr_q] = wr_data;
                        end
                        ptr_d = ptr_q + PTR_STEP;
                    end else if (rd_req) begin
                        rd_data_d = rd_byte;
                        ptr_d     = ptr_q + PTR_STEP;
                    end
                end
                default: begin
                    // ST_BAD: writes dropped, reads get the 8'hFF default.
                end
            endcase

            // STOP lets this cycle's byte complete, then returns to idle.
            if (bus_stop) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // State, pointer, register file and output registers with sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the register file is small and its reset contents are
            // architecturally visible, so every entry is reset explicitly.
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= (i == 0) ? RST_CTRL : 8'h00;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values computed above.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ctrl_out = regs_q[0];
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
